// File: rtl/lcd114_pkg.sv
// ST7789 command set, init ROM and RGB565 colours for the 1.14" LCD test driver.
package lcd114_pkg;

    localparam logic [7:0] SLPOUT = 8'h11;
    localparam logic [7:0] MADCTL = 8'h36;
    localparam logic [7:0] COLMOD = 8'h3A;
    localparam logic [7:0] INVON  = 8'h21;
    localparam logic [7:0] CASET  = 8'h2A;
    localparam logic [7:0] RASET  = 8'h2B;
    localparam logic [7:0] NORON  = 8'h13;
    localparam logic [7:0] DISPON = 8'h29;
    localparam logic [7:0] RAMWR  = 8'h2C;

    localparam logic [15:0] WHITE   = 16'hFFFF;
    localparam logic [15:0] YELLOW  = 16'hFFE0;
    localparam logic [15:0] CYAN    = 16'h07FF;
    localparam logic [15:0] GREEN   = 16'h07E0;
    localparam logic [15:0] MAGENTA = 16'hF81F;
    localparam logic [15:0] RED     = 16'hF800;
    localparam logic [15:0] BLUE    = 16'h001F;
    localparam logic [15:0] BLACK   = 16'h0000;

    localparam int INIT_LEN = 19;

    typedef struct packed {
        logic       is_delay;
        logic       rs;
        logic [7:0] data;
    } init_t;

    localparam logic [1:0] C = 2'b00;
    localparam logic [1:0] D = 2'b01;
    localparam logic [1:0] W = 2'b10;

    function automatic init_t init_rom(input logic [4:0] i);
        init_t e;
        case (i)
            5'd0:    e = {C, SLPOUT};
            5'd1:    e = {W, 8'h00};
            5'd2:    e = {C, MADCTL};
            5'd3:    e = {D, 8'h70};
            5'd4:    e = {C, COLMOD};
            5'd5:    e = {D, 8'h05};
            5'd6:    e = {C, INVON};
            5'd7:    e = {C, CASET};
            5'd8:    e = {D, 8'h00};
            5'd9:    e = {D, 8'h28};
            5'd10:   e = {D, 8'h01};
            5'd11:   e = {D, 8'h17};
            5'd12:   e = {C, RASET};
            5'd13:   e = {D, 8'h00};
            5'd14:   e = {D, 8'h35};
            5'd15:   e = {D, 8'h00};
            5'd16:   e = {D, 8'hBB};
            5'd17:   e = {C, NORON};
            default: e = {C, DISPON};
        endcase
        return e;
    endfunction

    function automatic logic [15:0] frame_color(input logic [1:0] f);
        logic [15:0] c;
        case (f)
            2'd0:    c = RED;
            2'd1:    c = GREEN;
            2'd2:    c = BLUE;
            default: c = WHITE;
        endcase
        return c;
    endfunction

    // 30-pixel-wide vertical bars across the 240-pixel line
    function automatic logic [15:0] bar_color(input logic [7:0] x);
        logic [15:0] c;
        case (x / 8'd30)
            8'd0:    c = WHITE;
            8'd1:    c = YELLOW;
            8'd2:    c = CYAN;
            8'd3:    c = GREEN;
            8'd4:    c = MAGENTA;
            8'd5:    c = RED;
            8'd6:    c = BLUE;
            default: c = BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lcd_spi_byte.sv
// SPI mode-0 byte serializer: 1 setup cycle, 8 two-cycle bits MSB first, 1 hold cycle.
module lcd_spi_byte (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] din,
    output logic       busy,
    output logic       done,
    output logic       lcd_clk,
    output logic       lcd_cs,
    output logic       lcd_rs,
    output logic       lcd_data
);

    logic [4:0] cnt;
    logic [7:0] sh;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            sh       <= '0;
            lcd_clk  <= 1'b0;
            lcd_cs   <= 1'b1;
            lcd_rs   <= 1'b0;
            lcd_data <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    busy     <= 1'b1;
                    cnt      <= '0;
                    sh       <= din;
                    lcd_cs   <= 1'b0;
                    lcd_rs   <= rs;
                    lcd_data <= din[7];
                end
            end else begin
                cnt <= cnt + 5'd1;
                unique case (1'b1)
                    !cnt[4]: begin
                        lcd_clk  <= cnt[0];
                        lcd_data <= sh[~cnt[3:1]];
                    end
                    cnt == 5'd16: lcd_clk <= 1'b0;
                    default: begin
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        lcd_cs   <= 1'b1;
                        lcd_data <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/lcd114_test.sv
// ST7789 240x135 test driver: panel reset, init ROM, endless RGB565 frames.
// Define LCD_COLOR_BARS_EN for 8 vertical colour bars instead of per-frame solid fill.
module lcd114_test #(
    parameter int T_RST  = 27000,
    parameter int T_WAKE = 3240000,
    parameter int H_RES  = 240,
    parameter int V_RES  = 135
) (
    input  logic clk,
    input  logic resetn,
    output logic ser_tx,
    input  logic ser_rx,
    output logic lcd_resetn,
    output logic lcd_clk,
    output logic lcd_cs,
    output logic lcd_rs,
    output logic lcd_data
);

    import lcd114_pkg::*;

    typedef enum logic [1:0] {RST_LOW, RST_WAIT, INIT, PIX} state_t;

    state_t      st;
    logic [31:0] tmr;
    logic [4:0]  ri;
    logic        pend, start, rs, pcmd, phi;
    logic [7:0]  din, x, y, frame;
    logic        busy, done;
    logic [15:0] col;
    init_t       ent;
    logic        unused_rx;

    assign ser_tx    = 1'b1;
    assign unused_rx = ser_rx;
    assign ent       = init_rom(ri);

`ifdef LCD_COLOR_BARS_EN
    assign col = bar_color(x);
`else
    assign col = frame_color(frame[1:0]);
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            st         <= RST_LOW;
            tmr        <= '0;
            ri         <= '0;
            pend       <= 1'b0;
            start      <= 1'b0;
            rs         <= 1'b0;
            din        <= '0;
            pcmd       <= 1'b1;
            phi        <= 1'b1;
            x          <= '0;
            y          <= '0;
            frame      <= '0;
            lcd_resetn <= 1'b0;
        end else begin
            start <= 1'b0;
            unique case (st)
                RST_LOW:
                    if (tmr == 32'(T_RST - 1)) begin
                        tmr        <= '0;
                        lcd_resetn <= 1'b1;
                        st         <= RST_WAIT;
                    end else tmr <= tmr + 32'd1;
                RST_WAIT:
                    if (tmr == 32'(T_RST - 1)) begin
                        tmr <= '0;
                        st  <= INIT;
                    end else tmr <= tmr + 32'd1;
                INIT:
                    if (pend) begin
                        if (done) begin
                            pend <= 1'b0;
                            if (ri == 5'(INIT_LEN - 1)) begin
                                st   <= PIX;
                                pcmd <= 1'b1;
                            end else ri <= ri + 5'd1;
                        end
                    end else if (ent.is_delay) begin
                        if (tmr == 32'(T_WAKE - 1)) begin
                            tmr <= '0;
                            ri  <= ri + 5'd1;
                        end else tmr <= tmr + 32'd1;
                    end else if (!busy) begin
                        start <= 1'b1;
                        pend  <= 1'b1;
                        rs    <= ent.rs;
                        din   <= ent.data;
                    end
                PIX:
                    if (pend) begin
                        if (done) begin
                            pend <= 1'b0;
                            if (pcmd) begin
                                pcmd <= 1'b0;
                                phi  <= 1'b1;
                            end else if (phi) begin
                                phi <= 1'b0;
                            end else begin
                                phi <= 1'b1;
                                if (x == 8'(H_RES - 1)) begin
                                    x <= '0;
                                    if (y == 8'(V_RES - 1)) begin
                                        y     <= '0;
                                        frame <= frame + 8'd1;
                                        pcmd  <= 1'b1;
                                    end else y <= y + 8'd1;
                                end else x <= x + 8'd1;
                            end
                        end
                    end else if (!busy) begin
                        start <= 1'b1;
                        pend  <= 1'b1;
                        rs    <= !pcmd;
                        din   <= pcmd ? RAMWR : (phi ? col[15:8] : col[7:0]);
                    end
                default: st <= RST_LOW;
            endcase
        end
    end

    lcd_spi_byte u_spi (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .rs       (rs),
        .din      (din),
        .busy     (busy),
        .done     (done),
        .lcd_clk  (lcd_clk),
        .lcd_cs   (lcd_cs),
        .lcd_rs   (lcd_rs),
        .lcd_data (lcd_data)
    );

endmodule

// File: tb/tb_lcd114_test.sv
// Bench for lcd114_test: decodes the SPI pins and compares against a stream model.
module tb_lcd114_test;

    localparam int TR = 4;
    localparam int TW = 8;
`ifdef LCD_COLOR_BARS_EN
    localparam int H = 240;
    localparam int V = 2;
    localparam int NFR = 2;
`else
    localparam int H = 16;
    localparam int V = 3;
    localparam int NFR = 5;
`endif
    localparam int FL = 1 + 2 * H * V;
    localparam int NINIT = 18;

    logic clk = 1'b0;
    logic resetn, ser_rx;
    logic ser_tx, lcd_resetn, lcd_clk, lcd_cs, lcd_rs, lcd_data;

    int n_run = 0;
    int n_fail = 0;

    logic [8:0] rom_q [NINIT] = '{
        9'h011, 9'h036, 9'h170, 9'h03A, 9'h105, 9'h021,
        9'h02A, 9'h100, 9'h128, 9'h101, 9'h117, 9'h02B,
        9'h100, 9'h135, 9'h100, 9'h1BB, 9'h013, 9'h029
    };
    logic [15:0] solid [4] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};
    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    lcd114_test #(.T_RST(TR), .T_WAKE(TW), .H_RES(H), .V_RES(V)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ser_tx     (ser_tx),
        .ser_rx     (ser_rx),
        .lcd_resetn (lcd_resetn),
        .lcd_clk    (lcd_clk),
        .lcd_cs     (lcd_cs),
        .lcd_rs     (lcd_rs),
        .lcd_data   (lcd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // k-th {rs,byte} on the wire after reset release
    function automatic logic [8:0] exp_byte(input int k);
        int j, r;
        logic [15:0] c;
        if (k < NINIT) return rom_q[k];
        j = k - NINIT;
        r = j % FL;
        if (r == 0) return 9'h02C;
`ifdef LCD_COLOR_BARS_EN
        c = bars[(((r - 1) / 2) % H) / 30];
`else
        c = solid[(j / FL) % 4];
`endif
        return ((r - 1) % 2 == 0) ? {1'b1, c[15:8]} : {1'b1, c[7:0]};
    endfunction

    int nbytes = 0;
    int nb = 0;
    int wlen = 0;
    int gap = 0;
    logic pcs = 1'b1;
    logic pclk = 1'b0;
    logic wrs = 1'b0;
    logic rsbad = 1'b0;
    logic [7:0] sr = '0;

    always @(negedge clk) begin
        if (!resetn) begin
            nbytes = 0; nb = 0; wlen = 0; gap = 0;
            pcs = 1'b1; pclk = 1'b0;
        end else begin
            if (!lcd_cs) begin
                if (pcs) begin
                    check("gap", 32'(gap >= ((nbytes == 1) ? TW : 1)), 32'd1);
                    wrs = lcd_rs; rsbad = 1'b0; nb = 0; wlen = 0;
                end
                wlen++;
                if (lcd_rs !== wrs) rsbad = 1'b1;
                if (lcd_clk && !pclk) begin
                    sr = {sr[6:0], lcd_data};
                    nb++;
                end
            end else begin
                if (!pcs) begin
                    check("bits", 32'(nb), 32'd8);
                    check("window", 32'(wlen), 32'd18);
                    check("rs_hold", 32'(rsbad), 32'd0);
                    check("tx_rstn", 32'({ser_tx, lcd_resetn}), 32'd3);
                    check($sformatf("byte%0d", nbytes), 32'({wrs, sr}),
                          32'(exp_byte(nbytes)));
                    nbytes++;
                    gap = 0;
                end
                gap++;
            end
            pcs = lcd_cs;
            pclk = lcd_clk;
        end
    end

    initial begin
        ser_rx = 1'b1;
        forever begin
            @(posedge clk);
            #2 ser_rx = 1'($urandom);
        end
    end

    task automatic do_reset();
        int n;
        @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_pins",
              32'({ser_tx, lcd_resetn, lcd_cs, lcd_clk, lcd_rs, lcd_data}),
              32'(6'b101000));
        repeat (4) @(posedge clk);
        #1 resetn = 1'b1;
        n = 0;
        repeat (50) begin
            @(negedge clk);
            if (lcd_resetn) break;
            n++;
        end
        check("rst_low", 32'(n), 32'(TR));
        n = 0;
        while (lcd_cs && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("cs_hold", 32'(n >= TR && n < 100), 32'd1);
    endtask

    task automatic wait_bytes(input int target);
        int c = 0;
        int budget = target * 25 + TW + 8 * TR + 100;
        while (nbytes < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("progress", 32'(nbytes >= target), 32'd1);
    endtask

    initial begin
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        do_reset();
        wait_bytes(NINIT + NFR * FL + 2);
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(0, 19)) @(posedge clk);
            do_reset();
            wait_bytes(int'($urandom_range(2, 60)));
        end
        repeat ($urandom_range(0, 19)) @(posedge clk);
        do_reset();
        wait_bytes(20);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
